// File: rtl/fetch_redirect_ctrl_if.sv
// fetch_redirect_ctrl_if: fetch redirect bus between the redirect sources and the fetch PC controller.
interface fetch_redirect_ctrl_if #(parameter int WIDTH = 31);
   logic           freeze;
   logic           commitRedirect;
   logic [WIDTH:0] commitTarget;
   logic           isJAL;
   logic [WIDTH:0] jalTarget;
   logic           predHit;
   logic [WIDTH:0] predTarget;
   logic [WIDTH:0] nextPC;
   logic           pcValid;
   logic [1:0]     redirectSrc;
   logic [15:0]    redirectCount;
   modport master (
      output freeze, commitRedirect, commitTarget, isJAL, jalTarget, predHit, predTarget,
      input  nextPC, pcValid, redirectSrc, redirectCount
   );
   modport slave (
      input  freeze, commitRedirect, commitTarget, isJAL, jalTarget, predHit, predTarget,
      output nextPC, pcValid, redirectSrc, redirectCount
   );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: fetch PC select (commit > JAL > prediction > +4) with post-commit recovery bubble.
// Define FETCH_REDIRECT_PERF_EN to enable the saturating commit-redirect counter.
module fetch_redirect_ctrl #(
   parameter int                WIDTH          = 31,
   parameter logic [WIDTH:0]    RESET_VECTOR   = '0,
   parameter int                RECOVER_CYCLES = 2
) (
   input logic                  clk,
   input logic                  globalReset,
   fetch_redirect_ctrl_if.slave bus
);
   typedef enum logic {RUN, RECOVER} state_t;
   localparam logic [2:0]     CNT_INIT = 3'(RECOVER_CYCLES);
   localparam logic [WIDTH:0] PC_STEP  = (WIDTH+1)'(4);
   state_t         state, state_n;
   logic [2:0]     cnt, cnt_n;
   logic [WIDTH:0] pc, pc_n;
   logic [1:0]     src, src_n;
   always_ff @(posedge clk or posedge globalReset) begin
      if (globalReset) begin
         state <= RUN;
         cnt   <= '0;
         pc    <= RESET_VECTOR;
         src   <= 2'b00;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pc    <= pc_n;
         src   <= src_n;
      end
   end
   // commit overrides everything; recovery drains the bubble regardless of freeze
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pc_n    = pc;
      src_n   = src;
      if (bus.commitRedirect) begin
         pc_n    = bus.commitTarget;
         src_n   = 2'b11;
         state_n = RECOVER_CYCLES > 0 ? RECOVER : RUN;
         cnt_n   = CNT_INIT;
      end else if (state == RECOVER) begin
         state_n = cnt > 3'd1 ? RECOVER : RUN;
         cnt_n   = cnt > 3'd1 ? cnt - 3'd1 : 3'd0;
      end else if (!bus.freeze) begin
         pc_n  = bus.isJAL ? bus.jalTarget : bus.predHit ? bus.predTarget : pc + PC_STEP;
         src_n = bus.isJAL ? 2'b10 : bus.predHit ? 2'b01 : 2'b00;
      end
   end
   assign bus.nextPC      = pc;
   assign bus.redirectSrc = src;
   assign bus.pcValid     = state == RUN;
`ifdef FETCH_REDIRECT_PERF_EN
   logic [15:0] perf_cnt;
   always_ff @(posedge clk or posedge globalReset) begin
      if (globalReset) perf_cnt <= '0;
      else if (bus.commitRedirect && perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 16'd1;
   end
   assign bus.redirectCount = perf_cnt;
`else
   assign bus.redirectCount = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed vector table plus reset-in-recovery sequence for fetch_redirect_ctrl.
module tb_fetch_redirect_ctrl;
   logic clk = 0;
   logic globalReset = 1;
   int   n_checks = 0;
   int   n_fail = 0;
   fetch_redirect_ctrl_if #(.WIDTH(31)) bus ();
   fetch_redirect_ctrl #(.WIDTH(31), .RESET_VECTOR(32'h0), .RECOVER_CYCLES(2)) dut (
      .clk(clk), .globalReset(globalReset), .bus(bus)
   );
   always #5 clk = ~clk;
`ifdef FETCH_REDIRECT_PERF_EN
   localparam logic [15:0] EXP_CNT = 16'd3;
`else
   localparam logic [15:0] EXP_CNT = 16'd0;
`endif
   typedef struct {
      logic        fz, cr;
      logic [31:0] ct;
      logic        jal;
      logic [31:0] jt;
      logic        ph;
      logic [31:0] pt;
      logic [31:0] pc;
      logic        v;
      logic [1:0]  src;
   } vec_t;
   vec_t vt [21];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(input logic fz, input logic cr, input logic [31:0] ct, input logic jal,
                        input logic [31:0] jt, input logic ph, input logic [31:0] pt);
      bus.freeze = fz; bus.commitRedirect = cr; bus.commitTarget = ct;
      bus.isJAL = jal; bus.jalTarget = jt; bus.predHit = ph; bus.predTarget = pt;
   endtask
   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
   initial begin
      //        fz cr ct          jal jt          ph pt            pc            v  src
      vt[0]  = '{0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h4,        1, 2'b00};
      vt[1]  = '{0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h8,        1, 2'b00};
      vt[2]  = '{0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'hC,        1, 2'b00};
      vt[3]  = '{0, 1, 32'h100,   1, 32'h200,   1, 32'h300,      32'h100,      0, 2'b11};
      vt[4]  = '{0, 0, 32'h0,     1, 32'h200,   1, 32'h300,      32'h100,      0, 2'b11};
      vt[5]  = '{0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h100,      1, 2'b11};
      vt[6]  = '{0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h104,      1, 2'b00};
      vt[7]  = '{0, 0, 32'h0,     1, 32'h200,   1, 32'h300,      32'h200,      1, 2'b10};
      vt[8]  = '{0, 0, 32'h0,     0, 32'h0,     1, 32'h40,       32'h40,       1, 2'b01};
      vt[9]  = '{1, 0, 32'h0,     0, 32'h0,     1, 32'h80,       32'h40,       1, 2'b01};
      vt[10] = '{1, 0, 32'h0,     0, 32'h0,     1, 32'h80,       32'h40,       1, 2'b01};
      vt[11] = '{1, 0, 32'h0,     0, 32'h0,     1, 32'h80,       32'h40,       1, 2'b01};
      vt[12] = '{0, 0, 32'h0,     0, 32'h0,     1, 32'h80,       32'h80,       1, 2'b01};
      vt[13] = '{1, 1, 32'h600,   0, 32'h0,     0, 32'h0,        32'h600,      0, 2'b11};
      vt[14] = '{0, 1, 32'h500,   1, 32'h700,   0, 32'h0,        32'h500,      0, 2'b11};
      vt[15] = '{0, 0, 32'h0,     0, 32'h0,     1, 32'h900,      32'h500,      0, 2'b11};
      vt[16] = '{0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h500,      1, 2'b11};
      vt[17] = '{1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h500,      1, 2'b11};
      vt[18] = '{0, 0, 32'h0,     0, 32'h0,     1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 2'b01};
      vt[19] = '{0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h0,        1, 2'b00};
      vt[20] = '{1, 0, 32'h0,     1, 32'h10,    0, 32'h0,        32'h0,        1, 2'b00};
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      check("reset_pc", bus.nextPC, 32'h0);
      check("reset_valid", 32'(bus.pcValid), 32'h1);
      check("reset_src", 32'(bus.redirectSrc), 32'h0);
      check("reset_cnt", 32'(bus.redirectCount), 32'h0);
      @(negedge clk);
      globalReset = 0;
      for (int i = 0; i < 21; i++) begin
         drive(vt[i].fz, vt[i].cr, vt[i].ct, vt[i].jal, vt[i].jt, vt[i].ph, vt[i].pt);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_pc", i), bus.nextPC, vt[i].pc);
         check($sformatf("vec%0d_valid", i), 32'(bus.pcValid), 32'(vt[i].v));
         check($sformatf("vec%0d_src", i), 32'(bus.redirectSrc), 32'(vt[i].src));
         @(negedge clk);
      end
      check("perf_count", 32'(bus.redirectCount), 32'(EXP_CNT));
      // reset asserted mid-recovery aborts immediately and ignores inputs
      drive(0, 1, 32'h700, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check("pre_rst_pc", bus.nextPC, 32'h700);
      check("pre_rst_valid", 32'(bus.pcValid), 32'h0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      globalReset = 1;
      #1;
      check("rst_async_pc", bus.nextPC, 32'h0);
      check("rst_async_valid", 32'(bus.pcValid), 32'h1);
      check("rst_async_src", 32'(bus.redirectSrc), 32'h0);
      check("rst_async_cnt", 32'(bus.redirectCount), 32'h0);
      drive(0, 1, 32'h800, 1, 32'h900, 1, 32'hA00);
      @(posedge clk);
      #1;
      check("rst_hold_pc", bus.nextPC, 32'h0);
      check("rst_hold_valid", 32'(bus.pcValid), 32'h1);
      check("rst_hold_cnt", 32'(bus.redirectCount), 32'h0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      globalReset = 0;
      @(posedge clk);
      #1;
      check("post_rst_pc", bus.nextPC, 32'h4);
      check("post_rst_src", 32'(bus.redirectSrc), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001: The block SHALL have parameter WIDTH, default 31, giving the PC MSB index (PC is WIDTH+1 bits).
REQ-002: The block SHALL have parameter RESET_VECTOR, default 0, giving the PC loaded on reset.
REQ-003: The block SHALL have parameter RECOVER_CYCLES, default 2, range 0-7, giving the fetch bubble cycles after a commit redirect.
REQ-004: The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005: The block SHALL have port globalReset, input, 1 bit, an asynchronous active-high reset.
REQ-006: The block SHALL have port freeze, input, 1 bit, a downstream stall request.
REQ-007: The block SHALL have ports commitRedirect (input, 1 bit) and commitTarget (input, WIDTH+1 bits), carrying the misprediction correction from commit.
REQ-008: The block SHALL have ports isJAL (input, 1 bit) and jalTarget (input, WIDTH+1 bits), carrying the JAL redirect from rename.
REQ-009: The block SHALL have ports predHit (input, 1 bit) and predTarget (input, WIDTH+1 bits), carrying the BTB/gshare taken prediction.
REQ-010: The block SHALL have port nextPC, output, WIDTH+1 bits, the registered fetch address.
REQ-011: The block SHALL have port pcValid, output, 1 bit, which is high when nextPC is a fetch to be consumed.
REQ-012: The block SHALL have port redirectSrc, output, 2 bits, the source that loaded nextPC: 00 sequential, 01 prediction, 10 JAL, 11 commit.
REQ-013: The block SHALL have port redirectCount, output, 16 bits, the performance counter described under Configuration.

Function
REQ-014: The block SHALL implement a two-state FSM with states RUN and RECOVER, plus a 3-bit bubble counter.
REQ-015: In RUN with freeze=0, nextPC SHALL load, in priority order, commitTarget if commitRedirect=1, else jalTarget if isJAL=1, else predTarget if predHit=1, else nextPC+4.
REQ-016: The sequential increment nextPC+4 SHALL wrap modulo 2^(WIDTH+1) with no overflow flag.
REQ-017: redirectSrc SHALL register the encoding of the source selected in the same edge that loads nextPC.
REQ-018: In RUN with freeze=1 and commitRedirect=0, nextPC and redirectSrc SHALL hold, and isJAL/predHit SHALL be ignored (the producers hold them).
REQ-019: commitRedirect=1 SHALL take effect in any state regardless of freeze, loading commitTarget with redirectSrc=11.
REQ-020: On commitRedirect with RECOVER_CYCLES>0, the FSM SHALL enter RECOVER with counter=RECOVER_CYCLES; with RECOVER_CYCLES=0 it SHALL stay in RUN.
REQ-021: In RECOVER, pcValid SHALL be 0, nextPC SHALL hold, isJAL/predHit SHALL be ignored (wrong path), and the counter SHALL decrement each edge independent of freeze.
REQ-022: When the counter reaches 1 in RECOVER, the next edge SHALL go to RUN, so pcValid is 0 for exactly RECOVER_CYCLES cycles.
REQ-023: A commitRedirect during RECOVER SHALL reload nextPC and restart the counter at RECOVER_CYCLES.
REQ-024: pcValid SHALL be 1 in RUN, including while frozen.

Reset
REQ-025: While globalReset=1, the block SHALL asynchronously set nextPC=RESET_VECTOR, redirectSrc=00, state=RUN, counter=0, and redirectCount=0; pcValid is then 1.
REQ-026: Reset asserted mid-RECOVER SHALL abort recovery immediately, and all inputs SHALL be ignored while reset is asserted.

Configuration
REQ-027: With macro FETCH_REDIRECT_PERF_EN defined, redirectCount SHALL increment by 1 on every edge that loads a commit-sourced PC and saturate at 16'hFFFF.
REQ-028: Without FETCH_REDIRECT_PERF_EN, redirectCount SHALL be constant 0 with no counter logic, and all other behaviour SHALL be identical.

Verification
REQ-029: Release reset, with no inputs for 3 cycles -> nextPC sequence 0x0, 0x4, 0x8, 0xC, pcValid=1, redirectSrc=00.
REQ-030: Assert commitRedirect, isJAL and predHit together (targets 0x100/0x200/0x300) -> nextPC=0x100, redirectSrc=11, pcValid=0 for 2 cycles, then 0x104 after one RUN cycle.
REQ-031: Assert freeze for 3 cycles at nextPC=0x40 with predHit (target 0x80) -> nextPC holds 0x40; after release, nextPC=0x80 with redirectSrc=01.
REQ-032: Assert commitRedirect to 0x500 in RECOVER cycle 1 -> recovery restarts: pcValid=0 for 2 further cycles, nextPC=0x500.
REQ-033: Hold nextPC=0xFFFFFFFC sequentially -> next nextPC=0x00000000.
REQ-034: Build with FETCH_REDIRECT_PERF_EN and issue 3 commit redirects -> redirectCount=3; assert globalReset mid-RECOVER -> nextPC=RESET_VECTOR, pcValid=1, count=0.
